// File: rtl/rs_ld_sd.sv
// rs_ld_sd: four-entry load/store reservation station with CDB snooping and age-ordered issue.
// Optional build macro RS_LDSD_INORDER_EN restricts issue to the oldest occupied entry.
module rs_ld_sd #(
    parameter logic [15:0] CDB_IDLE = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dispatch_valid,
    output logic        dispatch_ready,
    input  logic [2:0]  dispatch_op,
    input  logic [2:0]  dispatch_reg_dest,
    input  logic [3:0]  dispatch_imediate,
    input  logic        dispatch_ry_valid,
    input  logic [15:0] dispatch_ry_data,
    input  logic [2:0]  dispatch_ry_tag,
    input  logic [15:0] cdb,
    output logic        operands_ready,
    output logic [15:0] RY_data,
    output logic [3:0]  imediate,
    output logic [2:0]  reg_dest,
    output logic [2:0]  ULA_op,
    output logic [1:0]  RS_position,
    output logic [2:0]  occupancy
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } ent_state_t;

    localparam logic [2:0] OP_LD = 3'b010;
    localparam logic [2:0] OP_SD = 3'b011;

    ent_state_t  state_r   [4];
    logic [2:0]  op_r      [4];
    logic [2:0]  reg_r     [4];
    logic [3:0]  imm_r     [4];
    logic [15:0] ry_data_r [4];
    logic [2:0]  ry_tag_r  [4];
    logic [1:0]  age_r     [4];
    logic [2:0]  occupancy_r;
    logic        dispatch_ready_r;

    logic        operands_ready_r;
    logic [15:0] ry_out_r;
    logic [3:0]  imm_out_r;
    logic [2:0]  reg_out_r;
    logic [2:0]  op_out_r;
    logic [1:0]  pos_out_r;

    ent_state_t  st_n      [4];
    logic [15:0] data_n    [4];
    logic [1:0]  age_n     [4];
    logic [3:0]  alloc_s;

    logic        cdb_valid_s;
    logic [2:0]  cdb_tag_s;
    logic        accept_s;
    logic        bypass_s;
    logic        alloc_found_s;
    logic [1:0]  alloc_idx_s;
    logic        rel_s;
    logic [1:0]  rel_idx_s;
    logic [1:0]  rel_age_s;
    logic        sel_found_s;
    logic [1:0]  sel_idx_s;
    logic [1:0]  sel_age_s;
    logic [2:0]  occ_n_s;
    logic        any_free_n_s;
`ifdef RS_LDSD_INORDER_EN
    logic        old_found_s;
    logic [1:0]  old_idx_s;
    logic [1:0]  old_age_s;
`endif

    // CDB decode, allocation, release and dispatch acceptance
    always_comb begin
        cdb_valid_s   = (cdb != CDB_IDLE);
        cdb_tag_s     = {cdb[10], cdb[12:11]};
        alloc_found_s = 1'b0;
        alloc_idx_s   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (state_r[i] == ST_FREE) begin
                alloc_found_s = 1'b1;
                alloc_idx_s   = 2'(i);
            end else begin
            end
        end
        accept_s  = dispatch_valid & dispatch_ready_r & alloc_found_s &
                    ((dispatch_op == OP_LD) | (dispatch_op == OP_SD));
        bypass_s  = ~dispatch_ry_valid & cdb_valid_s & (dispatch_ry_tag == cdb_tag_s);
        rel_idx_s = cdb[12:11];
        rel_s     = cdb_valid_s & ~cdb[10] & (state_r[rel_idx_s] == ST_ISSUED);
        rel_age_s = age_r[rel_idx_s];
        for (int i = 0; i < 4; i++) begin
            alloc_s[i] = accept_s & (alloc_idx_s == 2'(i));
        end
    end

    // Issue selection; ages of occupied entries are unique, so no tie-break is needed
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = 2'd0;
        sel_age_s   = 2'd0;
`ifdef RS_LDSD_INORDER_EN
        old_found_s = 1'b0;
        old_idx_s   = 2'd0;
        old_age_s   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if ((state_r[i] != ST_FREE) && (!old_found_s || (age_r[i] > old_age_s))) begin
                old_found_s = 1'b1;
                old_idx_s   = 2'(i);
                old_age_s   = age_r[i];
            end else begin
            end
        end
        sel_found_s = old_found_s & (state_r[old_idx_s] == ST_READY);
        sel_idx_s   = old_idx_s;
        sel_age_s   = old_age_s;
`else
        for (int i = 0; i < 4; i++) begin
            if ((state_r[i] == ST_READY) && (!sel_found_s || (age_r[i] > sel_age_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = 2'(i);
                sel_age_s   = age_r[i];
            end else begin
            end
        end
`endif
    end

    // Per-entry next state, captured operand and composed age update
    always_comb begin
        occ_n_s      = 3'd0;
        any_free_n_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_n[i]   = state_r[i];
            data_n[i] = ry_data_r[i];
            age_n[i]  = age_r[i];
            case (state_r[i])
                ST_FREE: begin
                    if (alloc_s[i]) begin
                        st_n[i]   = (dispatch_ry_valid | bypass_s) ? ST_READY : ST_WAIT;
                        data_n[i] = dispatch_ry_valid ? dispatch_ry_data : {6'b0, cdb[9:0]};
                        age_n[i]  = 2'd0;
                    end else begin
                    end
                end
                ST_WAIT: begin
                    if (cdb_valid_s && (ry_tag_r[i] == cdb_tag_s)) begin
                        st_n[i]   = ST_READY;
                        data_n[i] = {6'b0, cdb[9:0]};
                    end else begin
                    end
                end
                ST_READY: begin
                    if (sel_found_s && (sel_idx_s == 2'(i))) begin
                        st_n[i] = ST_ISSUED;
                    end else begin
                    end
                end
                ST_ISSUED: begin
                    if (rel_s && (rel_idx_s == 2'(i))) begin
                        st_n[i] = ST_FREE;
                    end else begin
                    end
                end
                default: st_n[i] = ST_FREE;
            endcase
            if (state_r[i] != ST_FREE) begin
                if (rel_s && (rel_idx_s == 2'(i))) begin
                    age_n[i] = 2'd0;
                end else begin
                    age_n[i] = age_r[i] + {1'b0, accept_s}
                             - {1'b0, (rel_s && (age_r[i] > rel_age_s))};
                end
            end else begin
            end
            if (st_n[i] != ST_FREE) begin
                occ_n_s = occ_n_s + 3'd1;
            end else begin
                any_free_n_s = 1'b1;
            end
        end
    end

    // Entry storage plus registered occupancy / free-slot status
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i]   <= ST_FREE;
                op_r[i]      <= 3'd0;
                reg_r[i]     <= 3'd0;
                imm_r[i]     <= 4'd0;
                ry_data_r[i] <= 16'd0;
                ry_tag_r[i]  <= 3'd0;
                age_r[i]     <= 2'd0;
            end
            occupancy_r      <= 3'd0;
            dispatch_ready_r <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_r[i]   <= st_n[i];
                ry_data_r[i] <= data_n[i];
                age_r[i]     <= age_n[i];
                if (alloc_s[i]) begin
                    op_r[i]     <= dispatch_op;
                    reg_r[i]    <= dispatch_reg_dest;
                    imm_r[i]    <= dispatch_imediate;
                    ry_tag_r[i] <= dispatch_ry_tag;
                end
            end
            occupancy_r      <= occ_n_s;
            dispatch_ready_r <= any_free_n_s;
        end
    end

    // Issue output register: payload holds between issues, strobe is one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            operands_ready_r <= 1'b0;
            ry_out_r         <= 16'd0;
            imm_out_r        <= 4'd0;
            reg_out_r        <= 3'd0;
            op_out_r         <= 3'd0;
            pos_out_r        <= 2'd0;
        end else if (sel_found_s) begin
            operands_ready_r <= 1'b1;
            ry_out_r         <= ry_data_r[sel_idx_s];
            imm_out_r        <= imm_r[sel_idx_s];
            reg_out_r        <= reg_r[sel_idx_s];
            op_out_r         <= op_r[sel_idx_s];
            pos_out_r        <= sel_idx_s;
        end else begin
            operands_ready_r <= 1'b0;
        end
    end

    assign dispatch_ready = dispatch_ready_r;
    assign occupancy      = occupancy_r;
    assign operands_ready = operands_ready_r;
    assign RY_data        = ry_out_r;
    assign imediate       = imm_out_r;
    assign reg_dest       = reg_out_r;
    assign ULA_op         = op_out_r;
    assign RS_position    = pos_out_r;

endmodule
